// File: rtl/fpu_pkg.sv
// fpu_pkg: shared FPU opcode type, default latencies and latency lookup
package fpu_pkg;
    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2,
        OP_DIV = 2'd3
    } fpu_op_e;
    localparam int LAT_ADD_DEF = 3;
    localparam int LAT_MUL_DEF = 4;
    localparam int LAT_DIV_DEF = 8;
    function automatic int lat_of(fpu_op_e op, int la, int lm, int ld);
        return (op == OP_MUL) ? lm : (op == OP_DIV) ? ld : la;
    endfunction
endpackage

// File: rtl/fpu_issue_arbiter_if.sv
// fpu_issue_arbiter_if: requester handshake, issue and write-back signals of the FPU issue arbiter
interface fpu_issue_arbiter_if #(
    parameter int NREQ = 2,
    parameter int IDW  = 1
);
    logic [NREQ-1:0]   req_valid;
    logic [2*NREQ-1:0] req_op;
    logic [NREQ-1:0]   req_ready;
    logic              iss_valid;
    logic [1:0]        iss_op;
    logic [IDW-1:0]    iss_id;
    logic              wb_valid;
    logic [IDW-1:0]    wb_id;
    logic              busy;
    modport master (
        output req_valid, req_op,
        input  req_ready, iss_valid, iss_op, iss_id, wb_valid, wb_id, busy
    );
    modport slave (
        input  req_valid, req_op,
        output req_ready, iss_valid, iss_op, iss_id, wb_valid, wb_id, busy
    );
endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: one-hot round-robin grant, searching upward from ptr with wrap-around
module rr_arbiter #(
    parameter int N = 2,
    parameter int W = (N > 2) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] gnt
);
    logic found;
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++)
            for (int i = 0; i < N; i++)
                if (!found && req[i] && i == (int'(ptr) + k) % N) begin
                    gnt[i] = 1'b1;
                    found  = 1'b1;
                end
    end
endmodule

// File: rtl/fpu_issue_arbiter.sv
// fpu_issue_arbiter: round-robin issue to a shared pipelined FPU with write-back slot reservation.
// Define FPU_ARB_PERF_EN to add the saturating issue_cnt / conflict_cnt outputs.
module fpu_issue_arbiter
    import fpu_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int LAT_ADD = LAT_ADD_DEF,
    parameter int LAT_MUL = LAT_MUL_DEF,
    parameter int LAT_DIV = LAT_DIV_DEF
) (
    input  logic                 clk,
    input  logic                 arst_n,
    fpu_issue_arbiter_if.slave   bus
`ifdef FPU_ARB_PERF_EN
    ,
    output logic [15:0]          issue_cnt,
    output logic [15:0]          conflict_cnt
`endif
);
    localparam int IDW = (NREQ > 2) ? $clog2(NREQ) : 1;
    typedef struct packed {
        logic           v;
        logic [IDW-1:0] id;
    } rsv_t;
    // sr[j] reserves the write-back cycle j+1 cycles from now
    rsv_t            sr [0:LAT_DIV];
    logic [3:0]      slot_taken;
    logic [NREQ-1:0] elig, gnt;
    logic [IDW-1:0]  ptr, gidx;
    fpu_op_e         gop;
    int              glat;
    logic            xfer, any_rsv;
    always_comb begin
        slot_taken = {sr[LAT_DIV].v, sr[LAT_MUL].v, sr[LAT_ADD].v, sr[LAT_ADD].v};
        elig       = '0;
        for (int i = 0; i < NREQ; i++)
            elig[i] = bus.req_valid[i] && !slot_taken[bus.req_op[2*i +: 2]];
    end
    rr_arbiter #(.N(NREQ), .W(IDW)) u_rr (
        .req (elig),
        .ptr (ptr),
        .gnt (gnt)
    );
    always_comb begin
        gidx = '0;
        gop  = OP_ADD;
        for (int i = 0; i < NREQ; i++)
            if (gnt[i]) begin
                gidx = IDW'(i);
                gop  = fpu_op_e'(bus.req_op[2*i +: 2]);
            end
        glat    = lat_of(gop, LAT_ADD, LAT_MUL, LAT_DIV);
        xfer    = arst_n && |gnt;
        any_rsv = 1'b0;
        for (int j = 0; j <= LAT_DIV; j++)
            any_rsv = any_rsv | sr[j].v;
    end
    assign bus.req_ready = arst_n ? gnt : '0;
    assign bus.busy      = bus.iss_valid | any_rsv;
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            for (int j = 0; j <= LAT_DIV; j++)
                sr[j] <= '0;
            ptr           <= '0;
            bus.iss_valid <= 1'b0;
            bus.iss_op    <= '0;
            bus.iss_id    <= '0;
            bus.wb_valid  <= 1'b0;
            bus.wb_id     <= '0;
        end else begin
            for (int j = 0; j < LAT_DIV; j++)
                sr[j] <= (xfer && glat == j + 1) ? {1'b1, gidx} : sr[j+1];
            sr[LAT_DIV]   <= '0;
            bus.iss_valid <= xfer;
            bus.wb_valid  <= sr[0].v;
            bus.wb_id     <= sr[0].id;
            if (xfer) begin
                bus.iss_op <= gop;
                bus.iss_id <= gidx;
                ptr        <= (gidx == IDW'(NREQ - 1)) ? '0 : gidx + 1'b1;
            end
        end
    end
`ifdef FPU_ARB_PERF_EN
    logic conflict;
    assign conflict = |(bus.req_valid & ~elig);
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            issue_cnt    <= '0;
            conflict_cnt <= '0;
        end else begin
            if (xfer && ~&issue_cnt)
                issue_cnt <= issue_cnt + 16'd1;
            if (conflict && ~&conflict_cnt)
                conflict_cnt <= conflict_cnt + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_fpu_issue_arbiter.sv
// tb_fpu_issue_arbiter: directed scenarios plus randomized traffic against a cycle-schedule model
module tb_fpu_issue_arbiter;
    import fpu_pkg::*;
    localparam int NREQ = 3;
    localparam int IDW  = 2;
    localparam int LA   = LAT_ADD_DEF;
    localparam int LM   = LAT_MUL_DEF;
    localparam int LD   = LAT_DIV_DEF;
    localparam int NRND = 1500;
    logic clk    = 1'b0;
    logic arst_n = 1'b1;
    int   checks = 0;
    int   errors = 0;
    bit   rv  [0:4095];
    int   rid [0:4095];
`ifdef FPU_ARB_PERF_EN
    logic [15:0] issue_cnt, conflict_cnt;
`endif
    fpu_issue_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus ();
    fpu_issue_arbiter #(.NREQ(NREQ)) dut (
        .clk          (clk),
        .arst_n       (arst_n),
        .bus          (bus)
`ifdef FPU_ARB_PERF_EN
        ,
        .issue_cnt    (issue_cnt),
        .conflict_cnt (conflict_cnt)
`endif
    );
    always #5 clk = ~clk;

    function automatic int op_lat(int op);
        return (op == 2) ? LM : (op == 3) ? LD : LA;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.req_valid = '0;
        bus.req_op    = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        arst_n = 1'b0;
        tick();
        tick();
        arst_n = 1'b1;
    endtask

    task automatic test_reset();
        tick();
        arst_n        = 1'b0;
        bus.req_valid = 3'b111;
        bus.req_op    = '0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checks++; if (bus.req_ready !== 3'b000) begin errors++; $display("FAIL reset_ready: got %b expected 000", bus.req_ready); end
            checks++; if (bus.iss_valid !== 1'b0) begin errors++; $display("FAIL reset_iss_valid: got %b expected 0", bus.iss_valid); end
            checks++; if (bus.iss_op !== 2'd0 || bus.iss_id !== 2'd0) begin errors++; $display("FAIL reset_iss_fields: got op %0d id %0d expected 0 0", bus.iss_op, bus.iss_id); end
            checks++; if (bus.wb_valid !== 1'b0 || bus.wb_id !== 2'd0) begin errors++; $display("FAIL reset_wb: got valid %b id %0d expected 0 0", bus.wb_valid, bus.wb_id); end
            checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
            tick();
        end
    endtask

    task automatic test_single();
        do_reset();
        bus.req_valid = 3'b001;
        bus.req_op    = '0;
        @(negedge clk);
        checks++; if (bus.req_ready !== 3'b001) begin errors++; $display("FAIL single_ready: got %b expected 001", bus.req_ready); end
        for (int k = 1; k <= 6; k++) begin
            tick();
            idle_inputs();
            @(negedge clk);
            checks++; if (bus.iss_valid !== (k == 1)) begin errors++; $display("FAIL single_iss_valid@%0d: got %b expected %b", k, bus.iss_valid, k == 1); end
            checks++; if (bus.wb_valid !== (k == 4)) begin errors++; $display("FAIL single_wb_valid@%0d: got %b expected %b", k, bus.wb_valid, k == 4); end
            checks++; if (bus.busy !== (k < 4)) begin errors++; $display("FAIL single_busy@%0d: got %b expected %b", k, bus.busy, k < 4); end
            if (k == 1) begin
                checks++; if (bus.iss_op !== 2'd0 || bus.iss_id !== 2'd0) begin errors++; $display("FAIL single_iss_fields: got op %0d id %0d expected 0 0", bus.iss_op, bus.iss_id); end
            end
            if (k == 4) begin
                checks++; if (bus.wb_id !== 2'd0) begin errors++; $display("FAIL single_wb_id: got %0d expected 0", bus.wb_id); end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] er;
        do_reset();
        for (int k = 0; k <= 10; k++) begin
            if (k > 0) tick();
            bus.req_valid = (k < 6) ? 3'b011 : 3'b000;
            bus.req_op    = '0;
            @(negedge clk);
            er = (k >= 6) ? 3'b000 : (k % 2 == 0) ? 3'b001 : 3'b010;
            checks++; if (bus.req_ready !== er) begin errors++; $display("FAIL b2b_ready@%0d: got %b expected %b", k, bus.req_ready, er); end
            checks++; if (bus.iss_valid !== (k >= 1 && k <= 6)) begin errors++; $display("FAIL b2b_iss_valid@%0d: got %b", k, bus.iss_valid); end
            if (k >= 1 && k <= 6) begin
                checks++; if (bus.iss_id !== IDW'((k - 1) % 2)) begin errors++; $display("FAIL b2b_iss_id@%0d: got %0d expected %0d", k, bus.iss_id, (k - 1) % 2); end
            end
            checks++; if (bus.wb_valid !== (k >= 4 && k <= 9)) begin errors++; $display("FAIL b2b_wb_valid@%0d: got %b", k, bus.wb_valid); end
            if (k >= 4 && k <= 9) begin
                checks++; if (bus.wb_id !== IDW'((k - 4) % 2)) begin errors++; $display("FAIL b2b_wb_id@%0d: got %0d expected %0d", k, bus.wb_id, (k - 4) % 2); end
            end
        end
    endtask

    task automatic test_slot_conflict();
        logic [2:0] er;
        do_reset();
        for (int k = 0; k <= 8; k++) begin
            if (k > 0) tick();
            bus.req_valid = (k == 0) ? 3'b001 : (k <= 2) ? 3'b010 : 3'b000;
            bus.req_op    = (k == 0) ? 6'b000010 : 6'b000000;
            @(negedge clk);
            er = (k == 0) ? 3'b001 : (k == 2) ? 3'b010 : 3'b000;
            checks++; if (bus.req_ready !== er) begin errors++; $display("FAIL conflict_ready@%0d: got %b expected %b", k, bus.req_ready, er); end
            if (k == 1) begin
                checks++; if (bus.iss_valid !== 1'b1 || bus.iss_op !== 2'd2 || bus.iss_id !== 2'd0) begin errors++; $display("FAIL conflict_iss_mul: got v%b op%0d id%0d expected v1 op2 id0", bus.iss_valid, bus.iss_op, bus.iss_id); end
            end
            if (k == 3) begin
                checks++; if (bus.iss_valid !== 1'b1 || bus.iss_op !== 2'd0 || bus.iss_id !== 2'd1) begin errors++; $display("FAIL conflict_iss_add: got v%b op%0d id%0d expected v1 op0 id1", bus.iss_valid, bus.iss_op, bus.iss_id); end
            end
            if (k == 4) begin
                checks++; if (bus.iss_valid !== 1'b0 || bus.iss_op !== 2'd0 || bus.iss_id !== 2'd1) begin errors++; $display("FAIL conflict_iss_hold: got v%b op%0d id%0d expected v0 op0 id1", bus.iss_valid, bus.iss_op, bus.iss_id); end
            end
            checks++; if (bus.wb_valid !== (k == 5 || k == 6)) begin errors++; $display("FAIL conflict_wb_valid@%0d: got %b", k, bus.wb_valid); end
            if (k == 5 || k == 6) begin
                checks++; if (bus.wb_id !== IDW'(k - 5)) begin errors++; $display("FAIL conflict_wb_id@%0d: got %0d expected %0d", k, bus.wb_id, k - 5); end
            end
        end
`ifdef FPU_ARB_PERF_EN
        checks++; if (issue_cnt !== 16'd2) begin errors++; $display("FAIL perf_issue_cnt: got %0d expected 2", issue_cnt); end
        checks++; if (conflict_cnt !== 16'd1) begin errors++; $display("FAIL perf_conflict_cnt: got %0d expected 1", conflict_cnt); end
`endif
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int k = 0; k <= 12; k++) begin
            if (k > 0) tick();
            bus.req_valid = (k == 0) ? 3'b001 : 3'b000;
            bus.req_op    = (k == 0) ? 6'b000011 : 6'b000000;
            if (k == 3) arst_n = 1'b0;
            if (k == 5) arst_n = 1'b1;
            @(negedge clk);
            if (k == 1) begin
                checks++; if (bus.busy !== 1'b1 || bus.iss_op !== 2'd3) begin errors++; $display("FAIL midrst_div_issue: got busy %b op %0d expected 1 3", bus.busy, bus.iss_op); end
            end
            if (k == 3 || k == 4) begin
                checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy@%0d: got %b expected 0", k, bus.busy); end
            end
            if (k >= 1) begin
                checks++; if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL midrst_wb@%0d: got %b expected 0", k, bus.wb_valid); end
            end
        end
    endtask

    task automatic test_random();
        int ptr = 0;
        bit ev = 0;
        int eop = 0, eid = 0;
        int vld [NREQ];
        int ops [NREQ];
        int g;
        bit eb;
        logic [2:0] er;
        for (int c = 0; c < 4096; c++) begin rv[c] = 0; rid[c] = 0; end
        do_reset();
        for (int t = 0; t < NRND; t++) begin
            tick();
            for (int i = 0; i < NREQ; i++) begin
                vld[i] = ($urandom_range(9, 0) < 6) ? 1 : 0;
                ops[i] = $urandom_range(3, 0);
                bus.req_valid[i]      = vld[i][0];
                bus.req_op[2*i +: 2]  = ops[i][1:0];
            end
            @(negedge clk);
            g = -1;
            for (int k = 0; k < NREQ; k++) begin
                int i = (ptr + k) % NREQ;
                if (g < 0 && vld[i] == 1 && !rv[t + 1 + op_lat(ops[i])]) g = i;
            end
            er = (g < 0) ? 3'b000 : 3'(1 << g);
            eb = ev;
            for (int c = t + 1; c <= t + 1 + LD; c++) eb = eb | rv[c];
            checks++; if (bus.req_ready !== er) begin errors++; $display("FAIL rnd_ready@%0d: got %b expected %b", t, bus.req_ready, er); end
            checks++; if (bus.iss_valid !== ev || bus.iss_op !== 2'(eop) || bus.iss_id !== IDW'(eid)) begin errors++; $display("FAIL rnd_iss@%0d: got v%b op%0d id%0d expected v%b op%0d id%0d", t, bus.iss_valid, bus.iss_op, bus.iss_id, ev, eop, eid); end
            checks++; if (bus.wb_valid !== rv[t]) begin errors++; $display("FAIL rnd_wb_valid@%0d: got %b expected %b", t, bus.wb_valid, rv[t]); end
            if (rv[t]) begin
                checks++; if (bus.wb_id !== IDW'(rid[t])) begin errors++; $display("FAIL rnd_wb_id@%0d: got %0d expected %0d", t, bus.wb_id, rid[t]); end
            end
            checks++; if (bus.busy !== eb) begin errors++; $display("FAIL rnd_busy@%0d: got %b expected %b", t, bus.busy, eb); end
            ev = (g >= 0);
            if (g >= 0) begin
                eop = ops[g];
                eid = g;
                ptr = (g + 1) % NREQ;
                rv[t + 1 + op_lat(ops[g])]  = 1;
                rid[t + 1 + op_lat(ops[g])] = g;
            end
        end
        tick();
        idle_inputs();
    endtask

`ifdef FPU_ARB_PERF_EN
    task automatic test_perf_saturation();
        do_reset();
        bus.req_valid = 3'b001;
        bus.req_op    = '0;
        repeat (70000) tick();
        idle_inputs();
        @(negedge clk);
        checks++; if (issue_cnt !== 16'hFFFF) begin errors++; $display("FAIL perf_issue_sat: got %0d expected 65535", issue_cnt); end
        checks++; if (conflict_cnt !== 16'd0) begin errors++; $display("FAIL perf_conflict_idle: got %0d expected 0", conflict_cnt); end
    endtask
`endif

    initial begin
        idle_inputs();
        test_reset();
        test_single();
        test_back_to_back();
        test_slot_conflict();
        test_reset_mid();
        test_random();
`ifdef FPU_ARB_PERF_EN
        test_perf_saturation();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
